// File: rtl/memory_stage.sv
// memory_stage: data-memory access stage with a request/ack bus, load formatting and timeout
module memory_stage #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] regM_i_valE,
  input  logic [31:0] regM_i_valB,
  input  logic [3:0]  regM_i_mem_rw,
  input  logic        regM_i_wb_reg_wen,
  input  logic [4:0]  regM_i_wb_rd,
  input  logic [1:0]  regM_i_wb_valD_sel,
  input  logic [31:0] regM_i_pc,
  input  logic [31:0] regM_i_instr,
  input  logic        regM_i_commit,
  output logic        dmem_o_req,
  output logic        dmem_o_we,
  output logic [31:0] dmem_o_addr,
  output logic [31:0] dmem_o_wdata,
  output logic [3:0]  dmem_o_wstrb,
  input  logic        dmem_i_ack,
  input  logic [31:0] dmem_i_rdata,
  output logic [31:0] memory_o_valM,
  output logic        memory_o_stall,
  output logic        memory_o_wb_reg_wen,
  output logic [4:0]  memory_o_wb_rd,
  output logic [1:0]  memory_o_wb_valD_sel,
  output logic [31:0] memory_o_valE,
  output logic [31:0] memory_o_pc,
  output logic [31:0] memory_o_instr,
  output logic        memory_o_commit,
  output logic        memory_o_misalign,
  output logic        memory_o_bus_err
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t        state;
  logic [3:0]    op;
  logic [CW-1:0] cnt;
  logic          mem, store, mis;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic [31:0]   fmt, st_data;
  logic [3:0]    st_strb;
  // decode the incoming access, build store lanes and format returned load data
  always_comb begin
    mem     = regM_i_mem_rw != 4'd0 && regM_i_mem_rw <= 4'd8;
    store   = regM_i_mem_rw >= 4'd6 && regM_i_mem_rw <= 4'd8;
    mis     = ((regM_i_mem_rw == 4'd2 || regM_i_mem_rw == 4'd5 || regM_i_mem_rw == 4'd7) && regM_i_valE[0]) ||
              ((regM_i_mem_rw == 4'd3 || regM_i_mem_rw == 4'd8) && regM_i_valE[1:0] != 2'd0);
    st_data = regM_i_mem_rw == 4'd6 ? {4{regM_i_valB[7:0]}} :
              regM_i_mem_rw == 4'd7 ? {2{regM_i_valB[15:0]}} : regM_i_valB;
    st_strb = regM_i_mem_rw == 4'd6 ? 4'b0001 << regM_i_valE[1:0] :
              regM_i_mem_rw == 4'd7 ? 4'b0011 << {regM_i_valE[1], 1'b0} :
              regM_i_mem_rw == 4'd8 ? 4'b1111 : 4'b0000;
    rbyte   = dmem_i_rdata[{dmem_o_addr[1:0], 3'b000} +: 8];
    rhalf   = dmem_o_addr[1] ? dmem_i_rdata[31:16] : dmem_i_rdata[15:0];
    fmt     = op == 4'd1 ? {{24{rbyte[7]}}, rbyte} :
              op == 4'd4 ? {24'd0, rbyte} :
              op == 4'd2 ? {{16{rhalf[15]}}, rhalf} :
              op == 4'd5 ? {16'd0, rhalf} : dmem_i_rdata;
  end
  // stall, writeback/commit gating and combinational pass-throughs
  always_comb begin
    memory_o_stall       = (state == IDLE && mem) || state == BUSY;
    memory_o_wb_reg_wen  = regM_i_wb_reg_wen && !memory_o_stall && !memory_o_misalign && !memory_o_bus_err;
    memory_o_commit      = regM_i_commit && !memory_o_stall;
    memory_o_wb_rd       = regM_i_wb_rd;
    memory_o_wb_valD_sel = regM_i_wb_valD_sel;
    memory_o_valE        = regM_i_valE;
    memory_o_pc          = regM_i_pc;
    memory_o_instr       = regM_i_instr;
  end
  // access FSM: bus request fields are only written in IDLE so they stay stable while req is high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      op                <= 4'd0;
      cnt               <= '0;
      dmem_o_req        <= 1'b0;
      dmem_o_we         <= 1'b0;
      dmem_o_addr       <= 32'd0;
      dmem_o_wdata      <= 32'd0;
      dmem_o_wstrb      <= 4'd0;
      memory_o_valM     <= 32'd0;
      memory_o_misalign <= 1'b0;
      memory_o_bus_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (mem) begin
          if (mis) begin
            state             <= DONE;
            memory_o_misalign <= 1'b1;
          end else begin
            state        <= BUSY;
            op           <= regM_i_mem_rw;
            cnt          <= '0;
            dmem_o_req   <= 1'b1;
            dmem_o_we    <= store;
            dmem_o_addr  <= regM_i_valE;
            dmem_o_wdata <= st_data;
            dmem_o_wstrb <= st_strb;
          end
        end
        BUSY: if (dmem_i_ack) begin
          state      <= DONE;
          dmem_o_req <= 1'b0;
          if (op <= 4'd5) memory_o_valM <= fmt;
        end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
          state            <= DONE;
          dmem_o_req       <= 1'b0;
          memory_o_valM    <= 32'd0;
          memory_o_bus_err <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        DONE: begin
          state             <= IDLE;
          cnt               <= '0;
          memory_o_misalign <= 1'b0;
          memory_o_bus_err  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 The block SHALL have one parameter: ACK_TIMEOUT, 16, number of cycles to wait in BUSY for dmem_i_ack before declaring a bus error.
REQ-002 The block SHALL have these ports, clock and reset first:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- regM_i_valE  in  32  effective address.
- regM_i_valB  in  32  store data.
- regM_i_mem_rw  in  4  access code.
- regM_i_wb_reg_wen  in  1  writeback enable.
- regM_i_wb_rd  in  5  writeback register.
- regM_i_wb_valD_sel  in  2  writeback source select.
- regM_i_pc  in  32  commit tag.
- regM_i_instr  in  32  commit tag.
- regM_i_commit  in  1  commit tag.
- dmem_o_req  out  1  bus request.
- dmem_o_we  out  1  bus write enable.
- dmem_o_addr  out  32  bus address.
- dmem_o_wdata  out  32  bus write data.
- dmem_o_wstrb  out  4  bus byte strobes.
- dmem_i_ack  in  1  bus completion.
- dmem_i_rdata  in  32  bus read data.
- memory_o_valM  out  32  formatted load result.
- memory_o_stall  out  1  freezes regM and all upstream stages.
- memory_o_wb_reg_wen  out  1  writeback enable to the writeback stage.
- memory_o_wb_rd  out  5  writeback register to the writeback stage.
- memory_o_wb_valD_sel  out  2  writeback select to the writeback stage.
- memory_o_valE  out  32  pass-through of regM_i_valE.
- memory_o_pc  out  32  commit tag pass-through.
- memory_o_instr  out  32  commit tag pass-through.
- memory_o_commit  out  1  commit tag.
- memory_o_misalign  out  1  misaligned-access flag.
- memory_o_bus_err  out  1  bus-timeout flag.

Function
REQ-003 Access codes SHALL be 0 none, 1 lb, 2 lh, 3 lw, 4 lbu, 5 lhu, 6 sb, 7 sh, 8 sw; codes 9-15 SHALL be treated as none.
REQ-004 The FSM SHALL have states IDLE, BUSY and DONE, held in registers.
REQ-005 IDLE transitions:
- An aligned access in IDLE SHALL go to BUSY and register dmem_o_req=1 together with we, addr, wdata and wstrb.
- A misaligned access in IDLE SHALL go to DONE without issuing a request and SHALL register misalign=1.
- Misaligned means lh, lhu or sh with addr[0]=1, or lw or sw with addr[1:0]!=0.
REQ-006 BUSY transitions:
- dmem_i_ack=1 SHALL deassert dmem_o_req on the next edge, capture the formatted load data into valM, and go to DONE.
- After ACK_TIMEOUT BUSY cycles without ack, the FSM SHALL go to DONE with valM=0 and bus_err=1.
REQ-007 DONE SHALL last exactly one cycle and then return to IDLE; misalign and bus_err SHALL be high only during DONE.
REQ-008 memory_o_stall SHALL equal (IDLE and access code not none) or BUSY; it SHALL be 0 in DONE and for non-memory instructions.
REQ-009 Minimum access latency SHALL be 3 cycles (IDLE, BUSY with ack, DONE); a non-memory instruction SHALL pass through with 0 stall cycles.
REQ-010 Store lanes and strobes:
- sb: wdata is valB[7:0] replicated to all 4 lanes; wstrb = 4'b0001 << addr[1:0].
- sh: wdata is valB[15:0] replicated to both halves; wstrb = 4'b0011 << {addr[1],1'b0}.
- sw: wdata = valB; wstrb = 4'b1111.
- Loads: we=0 and wstrb=0.
REQ-011 Load formatting:
- lb/lbu SHALL select the byte at addr[1:0] and sign- or zero-extend it to 32 bits.
- lh/lhu SHALL select the half at addr[1] and sign- or zero-extend it.
- lw SHALL pass the word unchanged.
REQ-012 memory_o_valM SHALL hold its value until the next capture.
REQ-013 Writeback and commit gating:
- memory_o_wb_reg_wen SHALL equal regM_i_wb_reg_wen and not stall and not misalign and not bus_err.
- memory_o_commit SHALL equal regM_i_commit and not stall.
- memory_o_wb_rd, memory_o_wb_valD_sel, memory_o_valE, memory_o_pc and memory_o_instr SHALL be combinational pass-throughs.
REQ-014 A dmem_i_ack arriving in IDLE or DONE SHALL be ignored.
REQ-015 dmem_o_addr, dmem_o_we, dmem_o_wdata and dmem_o_wstrb SHALL be stable for the entire time dmem_o_req=1.

Reset
REQ-016 rst=0 SHALL asynchronously force state IDLE, dmem_o_req=0, we=0, wstrb=0, addr=0, wdata=0, valM=0, misalign=0, bus_err=0 and timeout counter=0.
REQ-017 An access in progress when reset is asserted SHALL be abandoned; no writeback and no commit SHALL result from it.
REQ-018 After reset is released, the block SHALL evaluate regM_i_mem_rw again from IDLE.

Verification
REQ-019 lw with addr 0x100 and ack after 2 BUSY cycles, rdata 0xDEADBEEF: stall high for 3 cycles, valM=0xDEADBEEF, wb_reg_wen high in DONE.
REQ-020 lb with addr 0x103 and rdata 0x80112233: valM=0xFFFFFF80; lbu with the same address and data: valM=0x00000080.
REQ-021 sh with addr 0x202 and valB 0x0000ABCD: wdata=0xABCDABCD, wstrb=4'b1100, we=1.
REQ-022 lw with addr 0x101: no dmem_o_req, misalign high for 1 cycle, wb_reg_wen low, stall high for 1 cycle.
REQ-023 lw with no ack: bus_err pulses after 16 BUSY cycles, valM=0, FSM returns to IDLE.
REQ-024 rst driven low mid-BUSY, then a late ack: dmem_o_req drops immediately, the ack is ignored, no commit occurs.
